rosc_rng: RTL and testbench
===========================

# rosc_rng

Random-word generator that consumes the divided ring-oscillator clock (`clk_out_div`) and turns its jitter into random bits in the system clock domain. It drives the oscillator enable, synchronizes the asynchronous oscillator signal and counts its rising edges over fixed sampling windows. It shifts the count parity into a word and hands the word to the game logic over a valid/ready handshake. The oscillator is powered only while a word is being generated.

## Interface
Parameters:
- `WINDOW_BITS`, 8: a sampling window lasts 2^WINDOW_BITS `clk` cycles; also the edge-counter width.
- `OUT_WIDTH`, 8: bits per random word.
- `WARMUP_CYCLES`, 16: cycles between enabling the oscillator and the first window. Must be ≥ 1.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `osc_in`  in  1  divided oscillator output; asynchronous to `clk`.
- `osc_en`  out  1  oscillator enable, registered.
- `req`  in  1  request a new word; level-sensitive.
- `rnd_valid`  out  1  `rnd_data` holds a completed word.
- `rnd_ready`  in  1  consumer accepts the word.
- `rnd_data`  out  OUT_WIDTH  random word.
- `busy`  out  1  high in WARMUP or SAMPLE.
- `osc_fault`  out  1  sticky flag: some window counted zero edges.

## Operation
- Synchronizer: 2 flops on `osc_in`, plus one "prev" flop. A rising edge is counted when sync=1 and prev=0. The synchronizer and prev flop run in every state.
- States:
  - IDLE: `osc_en`=0. If `req`=1 → WARMUP and clear the warmup counter.
  - WARMUP: `osc_en`=1, runs for WARMUP_CYCLES cycles, then → SAMPLE with the window counter, edge counter and bit counter cleared.
  - SAMPLE: `osc_en`=1. The window counter increments every cycle. The edge counter increments on each detected edge.
    - On the last window cycle (window counter = all ones), form `bit = (edge_cnt + edge_now)[0]`, where `edge_now` is an edge detected in that same cycle.
    - Shift the word left, inserting `bit` at bit 0. Clear the edge counter and increment the bit counter.
    - If this is the OUT_WIDTH-th bit → DONE, otherwise start the next window.
  - DONE: `osc_en`=0, `rnd_valid`=1, `rnd_data` stable. When `rnd_valid`&&`rnd_ready` → IDLE; a new request is taken from IDLE on the following cycle.
- `req` is only sampled in IDLE. Dropping `req` mid-word does not abort the word.
- Edge counter width is WINDOW_BITS. At most 2^(WINDOW_BITS-1) edges fit in a window, so the counter cannot overflow; no saturation logic is required.
- `osc_fault`: set when a window ends with total edge count 0, including `edge_now`. Once set, only reset clears it. A fault does not stop generation; that window contributes bit 0.
- `rnd_data` is updated only in SAMPLE. It holds its value through DONE and IDLE until the first shift of the next word.

## Timing
- Reset values (asynchronous): state IDLE, all counters 0, `osc_en`=0, `rnd_valid`=0, `rnd_data`=0, `busy`=0, `osc_fault`=0.
- Reset asserted mid-operation forces the reset values immediately. The partial word is discarded.
- `osc_en` and `busy` rise in the cycle after `req` is sampled high in IDLE.
- Latency: `rnd_valid` rises 1 + WARMUP_CYCLES + OUT_WIDTH·2^WINDOW_BITS cycles after the `clk` edge that samples `req` in IDLE. In that same cycle `osc_en` and `busy` fall.
- Handshake:
  - `rnd_valid` stays high and `rnd_data` stays constant for any number of cycles with `rnd_ready`=0.
  - The transfer happens in the cycle where both are high; `rnd_valid` is 0 in the next cycle.
  - `rnd_ready` is ignored while `rnd_valid`=0.
- Minimum word-to-word interval: latency + 1 (the DONE→IDLE cycle).
- Edge-to-count delay is 2 synchronizer cycles plus 1 prev cycle. Edges arriving in the last 2 cycles of a window may land in the next window. This is acceptable, and the bench must not require otherwise.

## Test plan
Bench settings: WINDOW_BITS=4, OUT_WIDTH=8, WARMUP_CYCLES=16.
- `osc_in` square wave, period 16 `clk` cycles, with `req` pulsed → exactly 1 edge per window, `rnd_data`=0xFF, `osc_fault`=0.
- `osc_in` square wave, period 4 cycles → 4 edges per window, `rnd_data`=0x00, `osc_fault`=0.
- `osc_in` held 0, with `req` → `rnd_data`=0x00, `osc_fault`=1 and still 1 after handshake and a second word; cleared only by `rst_n`=0.
- Latency: `req` sampled high in IDLE → `rnd_valid` rises exactly 145 cycles later. `osc_en` is high for exactly cycles 1..144 after the sample edge, and 0 in IDLE and DONE.
- Backpressure: hold `rnd_ready`=0 for 50 cycles after `rnd_valid` → `rnd_valid`=1 and `rnd_data` unchanged throughout, `osc_en`=0. Then `rnd_ready`=1 for one cycle → `rnd_valid`=0 the next cycle. With `req` held high, `busy`=1 two cycles after the transfer.
- Assert `rst_n`=0 mid-SAMPLE (cycle 60) → `osc_en`, `busy`, `rnd_valid`, `rnd_data` all 0 without waiting for a `clk` edge. After release with `req`=1, a full-latency word is produced.

Source files
------------

// File: rtl/rosc_rng.sv
// ---------------------------------------------------------------------------
// rosc_rng
//
// Turns ring-oscillator jitter into random words in the clk domain.
// The divided oscillator output is synchronized, its rising edges are counted
// over fixed windows of 2^WINDOW_BITS clk cycles, and the parity of each
// window's count becomes one bit of the output word. The oscillator is only
// enabled while a word is being produced (WARMUP and SAMPLE).
//
// Ports
//   clk        in   system clock, the only clock in the block
//   rst_n      in   asynchronous active-low reset
//   osc_in     in   divided oscillator output, asynchronous to clk
//   osc_en     out  oscillator enable (registered)
//   req        in   level request for a new word, looked at only in IDLE
//   rnd_valid  out  rnd_data holds a finished word
//   rnd_ready  in   consumer takes the word when rnd_valid is high
//   rnd_data   out  random word, OUT_WIDTH bits
//   busy       out  high while warming up or sampling
//   osc_fault  out  sticky: some window saw no oscillator edge at all
//
// State table
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | oscillator off, waiting for req
//   S_WARMUP | oscillator on, letting it settle for WARMUP_CYCLES cycles
//   S_SAMPLE | counting edges per window, one word bit per window
//   S_DONE   | oscillator off, word presented until rnd_ready
// ---------------------------------------------------------------------------
module rosc_rng #(
  parameter int WINDOW_BITS   = 8,
  parameter int OUT_WIDTH     = 8,
  parameter int WARMUP_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 osc_in,
  output logic                 osc_en,
  input  logic                 req,
  output logic                 rnd_valid,
  input  logic                 rnd_ready,
  output logic [OUT_WIDTH-1:0] rnd_data,
  output logic                 busy,
  output logic                 osc_fault
);

  // Warmup counter only needs to reach WARMUP_CYCLES-1.
  localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);

  // Bit counter only needs to reach OUT_WIDTH-1.
  localparam int BIT_W = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OUT_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                   r_sync1;
  logic                   r_sync2;
  logic                   r_prev;
  logic                   r_osc_en;
  logic                   r_fault;
  logic [WARM_W-1:0]      r_warm_cnt;
  logic [WINDOW_BITS-1:0] r_win_cnt;
  logic [WINDOW_BITS-1:0] r_edge_cnt;
  logic [BIT_W-1:0]       r_bit_cnt;
  logic [OUT_WIDTH-1:0]   r_word;

  logic                   w_edge;
  logic                   w_win_last;
  logic                   w_warm_done;
  logic                   w_word_done;
  logic [WINDOW_BITS-1:0] w_edge_total;
  logic                   w_bit;

  // Edge detection runs in every state so the pipeline is already primed
  // with real oscillator history by the time the first window opens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= osc_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge      = r_sync2 & ~r_prev;
  assign w_win_last  = &r_win_cnt;
  assign w_warm_done = (r_warm_cnt == WARM_LAST);
  assign w_word_done = w_win_last && (r_bit_cnt == BIT_LAST);

  // An edge seen on the window's last cycle still belongs to this window.
  // At most half the window can hold rising edges, so this cannot wrap.
  assign w_edge_total = r_edge_cnt + WINDOW_BITS'(w_edge);
  assign w_bit        = w_edge_total[0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_next = S_WARMUP;
        end
      end
      S_WARMUP: begin
        if (w_warm_done) begin
          w_next = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (w_word_done) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        // rnd_valid is implied by being in S_DONE.
        if (rnd_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Counters, shift register and fault flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_osc_en   <= 1'b0;
      r_fault    <= 1'b0;
      r_warm_cnt <= '0;
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_word     <= '0;
    end else begin
      // Registered from the next state so the enable lines up with busy.
      r_osc_en <= (w_next == S_WARMUP) || (w_next == S_SAMPLE);

      case (r_state)
        S_IDLE: begin
          r_warm_cnt <= '0;
        end
        S_WARMUP: begin
          r_warm_cnt <= r_warm_cnt + WARM_W'(1);
          r_win_cnt  <= '0;
          r_edge_cnt <= '0;
          r_bit_cnt  <= '0;
        end
        S_SAMPLE: begin
          // Window counter wraps from all ones back to zero on its own,
          // which starts the next window.
          r_win_cnt <= r_win_cnt + WINDOW_BITS'(1);
          if (w_win_last) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
            r_word     <= (r_word << 1) | OUT_WIDTH'(w_bit);
            if (w_edge_total == '0) begin
              r_fault <= 1'b1;
            end
          end else begin
            r_edge_cnt <= w_edge_total;
          end
        end
        default: begin
          // S_DONE: everything holds, rnd_data stays stable.
        end
      endcase
    end
  end

  assign osc_en    = r_osc_en;
  assign busy      = (r_state == S_WARMUP) || (r_state == S_SAMPLE);
  assign rnd_valid = (r_state == S_DONE);
  assign rnd_data  = r_word;
  assign osc_fault = r_fault;

endmodule

// File: tb/tb_rosc_rng.sv
// ---------------------------------------------------------------------------
// tb_rosc_rng
//
// Bench for rosc_rng with WINDOW_BITS=4, OUT_WIDTH=8, WARMUP_CYCLES=16.
// osc_in is driven on the falling clk edge; every rising-edge sample of
// osc_in is logged so a reference model can count oscillator edges per
// window directly from the sampled waveform.
// ---------------------------------------------------------------------------
module tb_rosc_rng;

  localparam int WB  = 4;
  localparam int OW  = 8;
  localparam int WU  = 16;
  localparam int WIN = 1 << WB;
  localparam int LAT = 1 + WU + OW * WIN;  // 145
  localparam int XS_N = 8192;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          osc_in = 1'b0;
  logic          req = 1'b0;
  logic          rnd_ready = 1'b0;
  logic          osc_en;
  logic          rnd_valid;
  logic          busy;
  logic          osc_fault;
  logic [OW-1:0] rnd_data;

  rosc_rng #(
    .WINDOW_BITS  (WB),
    .OUT_WIDTH    (OW),
    .WARMUP_CYCLES(WU)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .osc_in   (osc_in),
    .osc_en   (osc_en),
    .req      (req),
    .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready),
    .rnd_data (rnd_data),
    .busy     (busy),
    .osc_fault(osc_fault)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit xs[0:XS_N-1];
  bit exp_fault = 1'b0;

  int osc_period = 0;
  bit osc_rand = 1'b0;
  int ph = 0;

  // Log osc_in as seen by each rising clk edge; cyc is the index of the
  // next edge when read between edges.
  always @(posedge clk) begin
    if (cyc < XS_N) xs[cyc] = osc_in;
    cyc = cyc + 1;
  end

  // Oscillator stimulus: held low, square wave of osc_period cycles, or random.
  always @(negedge clk) begin
    if (osc_rand) begin
      if ($urandom_range(0, 2) == 0) osc_in = ~osc_in;
    end else if (osc_period == 0) begin
      osc_in = 1'b0;
    end else begin
      ph = ph + 1;
      if (ph >= osc_period / 2) begin
        ph = 0;
        osc_in = ~osc_in;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: req sampled at edge e0, first SAMPLE cycle follows edge e0+WU.
  // A rising edge sampled at edges m-2 (low) and m-1 (high) is counted in
  // the cycle after edge m. Each window is WIN consecutive such cycles.
  function automatic void model_word(input int e0, output logic [OW-1:0] w, output bit flt);
    w = '0;
    flt = 1'b0;
    for (int win = 0; win < OW; win++) begin
      int n;
      n = 0;
      for (int m = e0 + WU + win * WIN; m < e0 + WU + (win + 1) * WIN; m++) begin
        if (xs[m-1] && !xs[m-2]) n++;
      end
      w = {w[OW-2:0], n[0]};
      if (n == 0) flt = 1'b1;
    end
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 1'b0;
    rnd_ready = 1'b0;
    #1;
    check("rst_osc_en", osc_en, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", rnd_valid, 0);
    check("rst_data", rnd_data, 0);
    check("rst_fault", osc_fault, 0);
    exp_fault = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Requests a word from IDLE and waits for rnd_valid, checking latency,
  // the osc_en/busy profile and that rnd_data holds until the first shift.
  task automatic run_word(input int req_hold, input bit noise, output int e0,
                          output logic [OW-1:0] d, output bit ok);
    int bad_en;
    int bad_hold;
    int k;
    logic [OW-1:0] prev;
    logic exp_en;
    bad_en = 0;
    bad_hold = 0;
    ok = 1'b0;
    d = '0;
    @(negedge clk);
    prev = rnd_data;
    req = 1'b1;
    e0 = cyc;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      k = cyc - 1 - e0;
      if (k + 1 >= req_hold) req = 1'b0;
      exp_en = ((k + 1) <= LAT - 1);
      if (osc_en !== exp_en || busy !== exp_en) bad_en++;
      if (k < WU + WIN && rnd_data !== prev) bad_hold++;
      if (rnd_valid === 1'b1) begin
        ok = 1'b1;
        d = rnd_data;
        check("latency", k + 1, LAT);
      end else if (noise) begin
        rnd_ready = 1'($urandom_range(0, 1));
      end
    end
    rnd_ready = 1'b0;
    check("osc_en_busy_profile", bad_en, 0);
    check("data_hold_before_shift", bad_hold, 0);
    if (!ok) check("valid_timeout", 0, 1);
  endtask

  task automatic handshake(input int hold, input logic [OW-1:0] d);
    int bad;
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rnd_valid !== 1'b1 || rnd_data !== d || osc_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("hold_stable", bad, 0);
    rnd_ready = 1'b1;
    @(negedge clk);
    rnd_ready = 1'b0;
    check("valid_drop", rnd_valid, 0);
  endtask

  typedef struct {
    bit            do_rst;
    int            period;
    logic [OW-1:0] exp_data;
    bit            exp_flt;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int e0;
    int bad;
    logic [OW-1:0] d;
    logic [OW-1:0] md;
    bit ok;
    bit mf;

    tbl[0] = '{1'b1, 16, 8'hFF, 1'b0};
    tbl[1] = '{1'b0,  4, 8'h00, 1'b0};
    tbl[2] = '{1'b0,  2, 8'h00, 1'b0};
    tbl[3] = '{1'b0,  8, 8'h00, 1'b0};
    tbl[4] = '{1'b1,  0, 8'h00, 1'b1};
    tbl[5] = '{1'b0, 16, 8'hFF, 1'b1};

    // Power-on reset
    #2;
    rst_n = 1'b0;
    #1;
    check("por_osc_en", osc_en, 0);
    check("por_busy", busy, 0);
    check("por_valid", rnd_valid, 0);
    check("por_data", rnd_data, 0);
    check("por_fault", osc_fault, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Table: fixed oscillator patterns
    for (int t = 0; t < 6; t++) begin
      if (tbl[t].do_rst) apply_reset();
      osc_rand = 1'b0;
      osc_period = tbl[t].period;
      repeat (20) @(negedge clk);
      run_word(3, 1'b0, e0, d, ok);
      if (ok) begin
        model_word(e0, md, mf);
        exp_fault = exp_fault | mf;
        check("tbl_data", d, tbl[t].exp_data);
        check("tbl_data_model", d, md);
        check("tbl_fault", osc_fault, tbl[t].exp_flt);
        check("tbl_fault_model", osc_fault, exp_fault);
        handshake($urandom_range(0, 4), d);
      end
    end

    // Backpressure, restart with req held, then reset in mid-SAMPLE
    apply_reset();
    osc_period = 4;
    repeat (20) @(negedge clk);
    run_word(1000, 1'b0, e0, d, ok);
    check("bp_data", d, 8'h00);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rnd_valid !== 1'b1 || rnd_data !== d || osc_en !== 1'b0) bad++;
    end
    check("backpressure_hold", bad, 0);
    osc_period = 16;
    rnd_ready = 1'b1;
    @(negedge clk);
    rnd_ready = 1'b0;
    check("bp_valid_drop", rnd_valid, 0);
    @(negedge clk);
    check("bp_busy_restart", busy, 1);
    e0 = cyc - 1;
    while (cyc - 1 < e0 + 59) @(negedge clk);
    check("mid_sample_busy", busy, 1);
    check("mid_sample_data", rnd_data, 8'h03);
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    check("mid_rst_osc_en", osc_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", rnd_valid, 0);
    check("mid_rst_data", rnd_data, 0);
    exp_fault = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_word(5, 1'b0, e0, d, ok);
    if (ok) begin
      model_word(e0, md, mf);
      check("post_rst_data", d, 8'hFF);
      check("post_rst_model", d, md);
      handshake(1, d);
    end

    // Random oscillator against the reference model
    osc_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(1, 10)) @(negedge clk);
      run_word($urandom_range(1, 140), 1'b1, e0, d, ok);
      req = 1'b0;
      if (ok) begin
        model_word(e0, md, mf);
        exp_fault = exp_fault | mf;
        check("rand_data", d, md);
        check("rand_fault", osc_fault, exp_fault);
        handshake($urandom_range(0, 6), d);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
